// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Next-PC select codes and the offset shift helper.
package pc_pkg;

    localparam logic [2:0] SEL_SEQ = 3'd0;
    localparam logic [2:0] SEL_BR  = 3'd1;
    localparam logic [2:0] SEL_J   = 3'd2;
    localparam logic [2:0] SEL_JR  = 3'd3;
    localparam logic [2:0] SEL_RET = 3'd4;
    localparam logic [2:0] SEL_EXC = 3'd5;

    // Byte-addressed fetch scales word offsets by 4.
    function automatic int unsigned off_sh(input int unsigned step);
        return (step == 4) ? 2 : 0;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with count and sticky overflow.
// A push while full overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            ovf
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_m1;
    logic [CW-1:0]   cnt;
    logic            full;
    logic            pop_ok;

    assign ptr_m1 = ptr - PW'(1);
    assign full   = (cnt == CW'(RAS_DEPTH));
    assign empty  = (cnt == '0);
    assign pop_ok = pop && !empty;
    assign top    = mem[ptr_m1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (push && pop_ok) begin
            // Pop then push collapses to replacing the top entry.
            mem[ptr_m1] <= din;
        end else if (push) begin
            mem[ptr] <= din;
            ptr      <= ptr + PW'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else if (pop_ok) begin
            ptr <= ptr_m1;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC selection for the fetch path.
// Sources: sequential, branch, J/JAL, JR, return stack, exception.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned    PC_W      = 32,
    parameter int unsigned    PC_STEP   = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]    EXC_VEC   = 32'h20,
    parameter int unsigned    RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            exc,
    input  logic            branch_taken,
    input  logic [31:0]     imm_sign,
    input  logic            jump,
    input  logic [25:0]     jump_index,
    input  logic            link,
    input  logic            jr,
    input  logic            ret,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus,
    output logic            ras_empty,
    output logic            ras_ovf
);

    localparam int unsigned     OFF_SH = off_sh(PC_STEP);
    localparam logic [PC_W-1:0] EXC_PC = PC_W'(EXC_VEC);
    localparam logic [PC_W-1:0] J_MASK =
        (PC_W'(1) << (26 + OFF_SH)) - PC_W'(1);

    logic [PC_W-1:0] imm_w;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] j_tgt;
    logic [PC_W-1:0] r_tgt;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] nxt;
    logic [2:0]      sel;
    logic            upd;
    logic            push;
    logic            pop;

    assign pc_plus = pc + PC_W'(PC_STEP);
    assign imm_w   = PC_W'(signed'(imm_sign));
    assign br_tgt  = pc_plus + (imm_w << OFF_SH);
    assign j_tgt   = (pc_plus & ~J_MASK)
                   | (PC_W'(jump_index) << OFF_SH);
    assign r_tgt   = ras_empty ? jr_target : ras_top;

    // Exception overrides stall and squashes any stack update.
    assign upd  = exc || !stall;
    assign push = link && jump && !exc && !stall;
    assign pop  = ret && jr && !exc && !stall;

    always_comb begin
        sel = SEL_SEQ;
        if (exc) begin
            sel = SEL_EXC;
        end else if (jr && ret) begin
            sel = SEL_RET;
        end else if (jr) begin
            sel = SEL_JR;
        end else if (jump) begin
            sel = SEL_J;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        nxt = pc_plus;
        case (sel)
            SEL_EXC: nxt = EXC_PC;
            SEL_RET: nxt = r_tgt;
            SEL_JR:  nxt = jr_target;
            SEL_J:   nxt = j_tgt;
            SEL_BR:  nxt = br_tgt;
            default: nxt = pc_plus;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (upd) begin
            pc <= nxt;
        end
    end

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_plus),
        .top   (ras_top),
        .empty (ras_empty),
        .ovf   (ras_ovf)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: word- and byte-addressed sequencers on shared stimulus.
// Expected results are queued per step and checked after each edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        exc;
    logic        branch_taken;
    logic [31:0] imm_sign;
    logic        jump;
    logic [25:0] jump_index;
    logic        link;
    logic        jr;
    logic        ret;
    logic [31:0] jr_target;

    logic [31:0] pc_w, pcp_w, pc_b, pcp_b;
    logic        emp_w, ovf_w, emp_b, ovf_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        emp;
        logic        ovf;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pc_sequencer #(.PC_STEP(1)) u_w (
        .clk(clk), .reset(reset), .stall(stall), .exc(exc),
        .branch_taken(branch_taken), .imm_sign(imm_sign),
        .jump(jump), .jump_index(jump_index), .link(link),
        .jr(jr), .ret(ret), .jr_target(jr_target),
        .pc(pc_w), .pc_plus(pcp_w),
        .ras_empty(emp_w), .ras_ovf(ovf_w)
    );

    pc_sequencer #(.PC_STEP(4)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .exc(exc),
        .branch_taken(branch_taken), .imm_sign(imm_sign),
        .jump(jump), .jump_index(jump_index), .link(link),
        .jr(jr), .ret(ret), .jr_target(jr_target),
        .pc(pc_b), .pc_plus(pcp_b),
        .ras_empty(emp_b), .ras_ovf(ovf_b)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        stall = 0; exc = 0; branch_taken = 0; imm_sign = 0;
        jump = 0; jump_index = 0; link = 0;
        jr = 0; ret = 0; jr_target = 0;
    endtask

    task automatic tick(input string tag, input logic [31:0] p,
                        input logic e, input logic o);
        exp_t x;
        q.push_back('{tag, p, e, o});
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk({x.tag, ".pc"}, pc_w, x.pc);
        chk({x.tag, ".emp"}, 32'(emp_w), 32'(x.emp));
        chk({x.tag, ".ovf"}, 32'(ovf_w), 32'(x.ovf));
    endtask

    task automatic jal(input logic [25:0] idx);
        clr(); jump = 1; link = 1; jump_index = idx;
    endtask

    task automatic jret(input logic [31:0] t);
        clr(); jr = 1; ret = 1; jr_target = t;
    endtask

    initial begin
        clr();
        reset = 1;
        #7 reset = 0;
        chk("rst.pc", pc_w, 0);
        chk("rst.emp", 32'(emp_w), 1);
        chk("rst.ovf", 32'(ovf_w), 0);
        chk("rst.pcb", pc_b, 0);

        for (int i = 1; i <= 10; i++) tick("seq", 32'(i), 1, 0);
        chk("seq.pcb", pc_b, 40);
        chk("seq.pcp", pcp_w, 11);

        clr(); branch_taken = 1; imm_sign = -32'sd3;
        tick("br", 8, 1, 0);
        chk("br.pcb", pc_b, 32);

        clr(); jr = 1; jr_target = 5;
        tick("jr", 5, 1, 0);

        jal(26'h100);
        tick("jal", 32'h100, 0, 0);
        chk("jal.pcb", pc_b, 32'h400);

        jret(32'h77);
        tick("ret", 6, 1, 0);
        chk("ret.pcb", pc_b, 9);

        jal(26'h10); tick("p1", 32'h10, 0, 0);
        jal(26'h20); tick("p2", 32'h20, 0, 0);
        jal(26'h30); tick("p3", 32'h30, 0, 0);
        jal(26'h40); tick("p4", 32'h40, 0, 0);
        jal(26'h50); tick("p5", 32'h50, 0, 1);
        chk("p5.ovfb", 32'(ovf_b), 1);

        jret(32'h99); tick("r1", 32'h41, 0, 1);
        jret(32'h99); tick("r2", 32'h31, 0, 1);
        jret(32'h99); tick("r3", 32'h21, 0, 1);
        jret(32'h99); tick("r4", 32'h11, 1, 1);
        jret(32'h99); tick("r5", 32'h99, 1, 1);

        clr(); stall = 1; branch_taken = 1; imm_sign = 5;
        tick("st1", 32'h99, 1, 1);
        tick("st2", 32'h99, 1, 1);
        tick("st3", 32'h99, 1, 1);
        chk("st.pcp", pcp_w, 32'h9a);
        exc = 1;
        tick("stexc", 32'h20, 1, 1);

        jal(26'h60); tick("e.push", 32'h60, 0, 1);
        jal(26'h70); exc = 1;
        tick("e.jal", 32'h20, 0, 1);
        jret(32'h55); tick("e.ret", 32'h21, 1, 1);

        clr();
        #2 reset = 1;
        #1;
        chk("mrst.pc", pc_w, 0);
        chk("mrst.emp", 32'(emp_w), 1);
        chk("mrst.ovf", 32'(ovf_w), 0);
        #1 reset = 0;
        tick("post", 1, 1, 0);

        jal(26'h30); tick("pp.push", 32'h30, 0, 0);
        jret(32'h5); jump = 1; link = 1; jump_index = 26'h40;
        tick("pp.both", 2, 0, 0);
        jret(32'h5); tick("pp.pop", 32'h31, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
